stencil_stream_harness: RTL

- Synthesizable, parametrised source/sink harness for clockwork-generated stencil pipelines.
- Drives NUM_IN input stencil streams, with LANES words each, whenever the DUT pulses the per-stream read_en.
- Generates the post-reset flush pulse and captures the DUT's write_valid output stream.
- Checks captured data against an arithmetic golden sequence and reports done, fail and statistics.
- Generalises the single-lane, two-input, hand-written bench: channel count, lanes, patterns, timeout and on-chip checking are added, so on-FPGA runs need no simulator.

---
 rtl/stencil_stream_harness.sv | 126 ++++++++++++
 1 files changed

// File: rtl/stencil_stream_harness.sv
// stencil_stream_harness: source/sink harness that feeds stencil streams, flushes the DUT and checks its output stream.
module stencil_stream_harness #(
  parameter int WIDTH           = 16,
  parameter int NUM_IN          = 2,
  parameter int LANES           = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int NUM_OUTPUTS     = 64,
  parameter int SRC_STEP        = 1,
  parameter int SRC_SEED_STRIDE = 256,
  parameter int EXP_BASE        = 0,
  parameter int EXP_STEP        = 1,
  parameter int CHECK_EN        = 1,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            flush,
  input  logic [NUM_IN-1:0]               in_read_en,
  output logic [NUM_IN*LANES*WIDTH-1:0]   in_data,
  input  logic                            out_write_valid,
  input  logic [LANES*WIDTH-1:0]          out_write,
  output logic                            done,
  output logic                            fail,
  output logic [31:0]                     out_count,
  output logic [15:0]                     mismatch_count,
  output logic [31:0]                     first_bad_index,
  output logic [1:0]                      state
);
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_END} state_t;
  state_t            state_q;
  logic              flush_q, done_q, fail_q, wv_q, seen_q;
  logic [31:0]       fcnt_q, idle_q, acc_q, kl_q, cnt_q, fbi_q, low;
  logic [15:0]       mcnt_q;
  logic [16:0]       pop, msum;
  logic [WIDTH-1:0]  exp_q;
  logic [LANES-1:0]  mm_q, mm_d;
  logic [WIDTH-1:0]  data_q [NUM_IN*LANES];
  logic              run, acc, tmo, perr;
  for (genvar i = 0; i < NUM_IN*LANES; i++) begin : g_out
    assign in_data[i*WIDTH +: WIDTH] = data_q[i];
  end
  assign run  = state_q == S_RUN;
  assign acc  = run && out_write_valid;
  assign tmo  = run && !out_write_valid && idle_q == 32'(TIMEOUT_CYCLES-1);
  assign perr = ((state_q == S_IDLE || state_q == S_FLUSH) && (|in_read_en || out_write_valid)) ||
                (state_q == S_END && out_write_valid);
  always_comb begin
    mm_d = '0;
    for (int l = 0; l < LANES; l++)
      mm_d[l] = CHECK_EN != 0 && out_write[l*WIDTH +: WIDTH] != exp_q + WIDTH'(l*EXP_STEP);
  end
  // lowest mismatching lane wins, so scan downwards
  always_comb begin
    pop = '0;
    low = '0;
    for (int l = LANES-1; l >= 0; l--) begin
      pop = pop + 17'(mm_q[l]);
      low = mm_q[l] ? 32'(l) : low;
    end
  end
  assign msum = {1'b0, mcnt_q} + pop;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      flush_q <= 1'b0;
      fcnt_q  <= '0;
      idle_q  <= '0;
      acc_q   <= '0;
      exp_q   <= WIDTH'(EXP_BASE);
      wv_q    <= 1'b0;
      mm_q    <= '0;
      kl_q    <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      mcnt_q  <= '0;
      fbi_q   <= '1;
      seen_q  <= 1'b0;
      for (int i = 0; i < NUM_IN*LANES; i++)
        data_q[i] <= WIDTH'((i/LANES)*SRC_SEED_STRIDE + (i%LANES)*SRC_STEP);
    end else begin
      wv_q   <= acc;
      mm_q   <= acc ? mm_d : '0;
      kl_q   <= acc_q * 32'(LANES);
      cnt_q  <= cnt_q + 32'(wv_q);
      mcnt_q <= msum[16] ? 16'hFFFF : msum[15:0];
      done_q <= done_q | (acc_q == 32'(NUM_OUTPUTS));
      fail_q <= fail_q | (wv_q && |mm_q) | perr | tmo;
      if (wv_q && |mm_q && !seen_q) begin
        fbi_q  <= kl_q + low;
        seen_q <= 1'b1;
      end
      for (int i = 0; i < NUM_IN*LANES; i++)
        if (run && in_read_en[i/LANES]) data_q[i] <= data_q[i] + WIDTH'(LANES*SRC_STEP);
      if (acc) begin
        acc_q <= acc_q + 32'd1;
        exp_q <= exp_q + WIDTH'(LANES*EXP_STEP);
      end
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_FLUSH;
          flush_q <= 1'b1;
          fcnt_q  <= '0;
        end
        S_FLUSH: if (fcnt_q == 32'(FLUSH_CYCLES-1)) begin
          state_q <= S_RUN;
          flush_q <= 1'b0;
          idle_q  <= '0;
        end else fcnt_q <= fcnt_q + 32'd1;
        S_RUN: begin
          idle_q  <= out_write_valid ? '0 : idle_q + 32'd1;
          state_q <= ((acc && acc_q == 32'(NUM_OUTPUTS-1)) || tmo) ? S_END : S_RUN;
        end
        default: ;
      endcase
    end
  end
  assign flush           = flush_q;
  assign done            = done_q;
  assign fail            = fail_q;
  assign out_count       = cnt_q;
  assign mismatch_count  = mcnt_q;
  assign first_bad_index = fbi_q;
  assign state           = state_q;
endmodule
